emergency_scheduler: RTL and testbench
======================================

# emergency_scheduler

Sequences emergency-vehicle preemption at the four-lane intersection. It arbitrates among per-lane emergency requests with a round-robin policy. Before granting, it drains the currently green lanes through yellow and an all-red clearance, then drives the one-hot `emergencyLane` vector consumed by the emergency light-code mapper. It sits between the sensor/request inputs and the mapper, and freezes the normal signal controller while preemption is active.

## Interface
- `YELLOW_CYCLES`, 4: cycles of yellow before any clearance (≥1)
- `CLEAR_CYCLES`, 2: all-red clearance cycles (≥1)
- `MIN_GREEN`, 8: minimum cycles an emergency grant is held (≥1)
- `MAX_GREEN`, 32: grant limit when another lane is waiting (≥ `MIN_GREEN`)
- `clk`  in  1  single system clock; all state on rising edge
- `rstN`  in  1  asynchronous, active-low reset
- `emergencyReq[0:3]`  in  4  level request per lane; bit 0 = lane 0
- `normalGreen[0:3]`  in  4  lanes currently green under the normal controller
- `emergencyLane[0:3]`  out  4  one-hot granted lane; feeds the mapper
- `yellowLane[0:3]`  out  4  lanes to be shown yellow this cycle
- `preempt`  out  1  high whenever not IDLE; freezes the normal controller, and normal light codes are ignored
- `allRed`  out  1  high during clearance

## Operation
- States: IDLE, YELLOW, CLEAR, GRANT. Each state has a source mask, `yMask`.
- IDLE, no request: stay. All outputs are 0.
- IDLE, any request bit set: latch `yMask = normalGreen`.
  - If `yMask` is nonzero, go to YELLOW.
  - If `yMask` is zero, go to CLEAR.
- YELLOW: `yellowLane = yMask`. After `YELLOW_CYCLES`, go to CLEAR.
- CLEAR: `allRed = 1`. In the last CLEAR cycle, arbitrate over the current `emergencyReq`.
  - Winner exists: go to GRANT and latch the one-hot grant.
  - No winner: go to IDLE. A request that vanished during the drain is dropped.
- Round-robin arbitration: search starts at `(ptr+1) mod 4`. On each grant, `ptr` is set to the granted lane. Reset `ptr` = 3, so lane 0 has first priority.
- GRANT: `emergencyLane` = latched grant. The counter increments each cycle. Exit to YELLOW with `yMask` = grant when either condition holds:
  - `cnt ≥ MIN_GREEN` and the granted request is low; or
  - `cnt ≥ MAX_GREEN` and any other request is high.
- GRANT with the request held and no other requester: stay indefinitely; the counter saturates at `MAX_GREEN`.
- A request dropping before `MIN_GREEN` is ignored; the grant is held to `MIN_GREEN`.
- Return to normal is only via CLEAR → IDLE, so clearance is guaranteed between any two greens.
- Exactly one of {`emergencyLane` ≠ 0, `yellowLane` ≠ 0, `allRed`} is active in any non-IDLE cycle. `emergencyLane` is always zero or one-hot.
- Counter width: `$clog2(MAX_GREEN+1)`. It clears on every state entry.

## Timing
- All outputs are registered, decoded from state. They change only after a clock edge.
- Reset values: state IDLE, `ptr` = 3, counter 0, `yMask` 0; all outputs 0.
- Request sampled high in IDLE at edge 0, with `normalGreen` ≠ 0:
  - `preempt` and `yellowLane` are valid in cycles 1..Y.
  - `allRed` in cycles Y+1..Y+C.
  - `emergencyLane` from cycle Y+C+1.
- With `normalGreen` = 0 at edge 0, YELLOW is skipped and `emergencyLane` is valid from cycle C+1.
- Release: the exit condition is met at edge k. Yellow runs for Y cycles, then `allRed` for C cycles. `preempt` falls at cycle k+Y+C+1 if no request is pending.
- Reset asserted mid-operation: all outputs are 0 immediately (asynchronous). Operation resumes in IDLE on the first edge after `rstN` rises.
- `normalGreen` is ignored outside the IDLE→exit edge.

## Structure
- Shared package `traffic_pkg` holds:
  - `NUM_LANES` = 4
  - state enum `emerg_state_t` {IDLE, YELLOW, CLEAR, GRANT}
  - lane light-code constants
- Sub-module `rr_arbiter`: combinational 4-way round-robin. Inputs are request and pointer; output is a one-hot grant plus a valid bit. The pointer register stays in `emergency_scheduler`.

## Test plan
- Reset, then `normalGreen` = 4'b1100 and `emergencyReq` = 4'b0010 from edge 0, held. Expected:
  - `yellowLane` = 1100 in cycles 1–4
  - `allRed` in cycles 5–6
  - `emergencyLane` = 0010 from cycle 7
- Granted lane 1 drops its request at grant cycle 3. Grant is held to `MIN_GREEN` = 8, then yellow on 0010 for 4 cycles and all-red for 2; `preempt` then goes to 0.
- Lanes 0 and 2 both request continuously. Lane 0 is granted first. At `cnt` = 32, lane 0 yellows and clears, then lane 2 is granted; lane 0 is granted again next.
- Request pulse of 1 cycle in IDLE that is low by the end of CLEAR: the full yellow/clear sequence runs, no grant is issued, and the block returns to IDLE with `emergencyLane` never nonzero.
- `rstN` asserted low in GRANT: all outputs are 0 within the same cycle. After release, IDLE with `ptr` = 3: simultaneous requests 1111 grant lane 0.
- Continuous invariant check on every cycle:
  - `emergencyLane` is one-hot or zero.
  - Never green while `allRed` or yellow is active.
  - At least `CLEAR_CYCLES` of `allRed` between distinct grants.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared intersection definitions: lane count, preemption state encoding,
// lane light codes and a one-hot to index helper.
package traffic_pkg;

  localparam int unsigned NUM_LANES  = 4;
  localparam int unsigned LANE_IDX_W = $clog2(NUM_LANES);

  typedef enum logic [1:0] {
    IDLE,
    YELLOW,
    CLEAR,
    GRANT
  } emerg_state_t;

  localparam logic [1:0] LIGHT_RED    = 2'b00;
  localparam logic [1:0] LIGHT_YELLOW = 2'b01;
  localparam logic [1:0] LIGHT_GREEN  = 2'b10;

  function automatic logic [LANE_IDX_W-1:0] onehot_to_idx(input logic [NUM_LANES-1:0] oh);
    onehot_to_idx = '0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      if (oh[i]) onehot_to_idx = LANE_IDX_W'(i);
    end
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts one lane past ptr and
// wraps, returning a one-hot grant and a valid flag.
module rr_arbiter
  import traffic_pkg::*;
(
  input  logic [NUM_LANES-1:0]  req,
  input  logic [LANE_IDX_W-1:0] ptr,
  output logic [NUM_LANES-1:0]  grant,
  output logic                  valid
);

  logic [LANE_IDX_W-1:0] idx;

  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = '0;
    for (int unsigned i = 1; i <= NUM_LANES; i++) begin
      idx = LANE_IDX_W'((32'(ptr) + i) % NUM_LANES);
      if (!valid && req[idx]) begin
        grant[idx] = 1'b1;
        valid      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/emergency_scheduler.sv
// Emergency preemption sequencer: drains green lanes through yellow and
// all-red clearance, then grants one emergency lane chosen round-robin.
module emergency_scheduler
  import traffic_pkg::*;
#(
  parameter int unsigned YELLOW_CYCLES = 4,
  parameter int unsigned CLEAR_CYCLES  = 2,
  parameter int unsigned MIN_GREEN     = 8,
  parameter int unsigned MAX_GREEN     = 32
) (
  input  logic                 clk,
  input  logic                 rstN,
  input  logic [NUM_LANES-1:0] emergencyReq,
  input  logic [NUM_LANES-1:0] normalGreen,
  output logic [NUM_LANES-1:0] emergencyLane,
  output logic [NUM_LANES-1:0] yellowLane,
  output logic                 preempt,
  output logic                 allRed
);

  localparam int unsigned CW = $clog2(MAX_GREEN + 1);
  localparam logic [CW-1:0] Y_LAST  = CW'(YELLOW_CYCLES - 1);
  localparam logic [CW-1:0] C_LAST  = CW'(CLEAR_CYCLES - 1);
  localparam logic [CW-1:0] MIN_CNT = CW'(MIN_GREEN);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_GREEN);

  emerg_state_t          state;
  logic [LANE_IDX_W-1:0] ptr;
  logic [CW-1:0]         cnt;
  logic [CW-1:0]         cnt_inc;
  logic [NUM_LANES-1:0]  y_mask;
  logic [NUM_LANES-1:0]  arb_grant;
  logic                  arb_valid;
  logic                  grant_exit;

  rr_arbiter u_arb (
    .req   (emergencyReq),
    .ptr   (ptr),
    .grant (arb_grant),
    .valid (arb_valid)
  );

  // The yellow output is the latched source mask itself; it is cleared on
  // leaving YELLOW so it only shows while draining.
  assign yellowLane = y_mask;

  // Exit tests use the count including the current cycle, so a grant lasts
  // exactly MIN_GREEN cycles at minimum and MAX_GREEN under contention.
  always_comb begin
    cnt_inc    = (cnt == MAX_CNT) ? cnt : cnt + CW'(1);
    grant_exit = ((cnt_inc >= MIN_CNT) && !(|(emergencyReq & emergencyLane))) ||
                 ((cnt_inc >= MAX_CNT) &&  (|(emergencyReq & ~emergencyLane)));
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state         <= IDLE;
      ptr           <= LANE_IDX_W'(NUM_LANES - 1);
      cnt           <= '0;
      y_mask        <= '0;
      emergencyLane <= '0;
      preempt       <= 1'b0;
      allRed        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|emergencyReq) begin
            cnt     <= '0;
            preempt <= 1'b1;
            y_mask  <= normalGreen;
            if (|normalGreen) begin
              state <= YELLOW;
            end else begin
              state  <= CLEAR;
              allRed <= 1'b1;
            end
          end
        end
        YELLOW: begin
          if (cnt == Y_LAST) begin
            state  <= CLEAR;
            cnt    <= '0;
            y_mask <= '0;
            allRed <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        CLEAR: begin
          if (cnt == C_LAST) begin
            cnt    <= '0;
            allRed <= 1'b0;
            if (arb_valid) begin
              state         <= GRANT;
              emergencyLane <= arb_grant;
              ptr           <= onehot_to_idx(arb_grant);
            end else begin
              state   <= IDLE;
              preempt <= 1'b0;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        GRANT: begin
          if (grant_exit) begin
            state         <= YELLOW;
            cnt           <= '0;
            y_mask        <= emergencyLane;
            emergencyLane <= '0;
          end else begin
            cnt <= cnt_inc;
          end
        end
        default: begin
          state         <= IDLE;
          cnt           <= '0;
          y_mask        <= '0;
          emergencyLane <= '0;
          preempt       <= 1'b0;
          allRed        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_emergency_scheduler.sv
// Self-checking bench for emergency_scheduler: directed scenarios followed by
// random requests, all compared against a phase/countdown reference model.
module tb_emergency_scheduler;

  localparam int Y    = 4;
  localparam int C    = 2;
  localparam int MINC = 8;
  localparam int MAXC = 32;

  logic       clk = 1'b0;
  logic       rstN;
  logic [3:0] emergencyReq;
  logic [3:0] normalGreen;
  logic [3:0] emergencyLane;
  logic [3:0] yellowLane;
  logic       preempt;
  logic       allRed;

  always #5 clk = ~clk;

  emergency_scheduler #(
    .YELLOW_CYCLES (Y),
    .CLEAR_CYCLES  (C),
    .MIN_GREEN     (MINC),
    .MAX_GREEN     (MAXC)
  ) dut (
    .clk           (clk),
    .rstN          (rstN),
    .emergencyReq  (emergencyReq),
    .normalGreen   (normalGreen),
    .emergencyLane (emergencyLane),
    .yellowLane    (yellowLane),
    .preempt       (preempt),
    .allRed        (allRed)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: phase 0 idle, 1 draining, 2 clearance, 3 emergency green.
  int         m_phase;
  int         m_left;
  int         m_held;
  int         m_lane;
  int         m_ptr;
  logic [3:0] m_ymask;

  int         ar_run;
  logic [3:0] prev_lane;
  logic [3:0] grant_log[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase   = 0;
    m_left    = 0;
    m_held    = 0;
    m_lane    = 0;
    m_ptr     = 3;
    m_ymask   = '0;
    ar_run    = 0;
    prev_lane = '0;
  endtask

  task automatic model_step();
    logic [3:0] req;
    logic       found;
    req = emergencyReq;
    case (m_phase)
      0: if (req != 0) begin
        m_ymask = normalGreen;
        if (normalGreen != 0) begin m_phase = 1; m_left = Y; end
        else begin m_phase = 2; m_left = C; end
      end
      1: begin
        m_left--;
        if (m_left == 0) begin m_phase = 2; m_left = C; end
      end
      2: begin
        m_left--;
        if (m_left == 0) begin
          found = 1'b0;
          for (int k = 1; k <= 4; k++) begin
            if (!found && req[(m_ptr + k) % 4]) begin
              found  = 1'b1;
              m_lane = (m_ptr + k) % 4;
            end
          end
          if (found) begin m_phase = 3; m_ptr = m_lane; m_held = 0; end
          else m_phase = 0;
        end
      end
      default: begin
        m_held++;
        if ((m_held >= MINC && !req[m_lane]) ||
            (m_held >= MAXC && (req & ~(4'b0001 << m_lane)) != 0)) begin
          m_phase = 1;
          m_left  = Y;
          m_ymask = 4'b0001 << m_lane;
        end
      end
    endcase
  endtask

  task automatic compare();
    logic [3:0] exp_lane;
    exp_lane = (m_phase == 3) ? (4'b0001 << m_lane) : 4'b0000;
    check("lane", emergencyLane, exp_lane);
    check("yellow", yellowLane, (m_phase == 1) ? m_ymask : 4'b0000);
    check("allred", allRed, m_phase == 2);
    check("preempt", preempt, m_phase != 0);
    check("onehot", $countones(emergencyLane) <= 1, 1);
    if (preempt)
      check("exclusive", int'(emergencyLane != 0) + int'(yellowLane != 0) + int'(allRed), 1);
    if (allRed) ar_run++;
    if (emergencyLane != 0 && prev_lane == 0) begin
      check("clear_gap", ar_run >= C, 1);
      grant_log.push_back(emergencyLane);
      ar_run = 0;
    end
    prev_lane = emergencyLane;
  endtask

  task automatic cycle();
    @(posedge clk);
    if (!rstN) model_reset();
    else model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic run_to_idle(input int budget);
    int n;
    n = 0;
    while (preempt && n < budget) begin
      cycle();
      n++;
    end
    check("idle_timeout", preempt, 0);
  endtask

  task automatic do_reset();
    rstN = 1'b0;
    cycle();
    cycle();
    rstN = 1'b1;
  endtask

  initial begin
    int cnt_g, cnt_y, cnt_c, n;
    logic seen;
    emergencyReq = '0;
    normalGreen  = '0;
    rstN         = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset();
    check("rst_lane", emergencyLane, 0);
    check("rst_yellow", yellowLane, 0);
    check("rst_preempt", preempt, 0);

    // Drain 1100, then grant lane 1.
    normalGreen  = 4'b1100;
    emergencyReq = 4'b0010;
    for (int c = 1; c <= Y + C + 1; c++) begin
      cycle();
      if (c <= Y) check("s1_yellow", yellowLane, 4'b1100);
      else if (c <= Y + C) check("s1_allred", allRed, 1);
      else check("s1_grant", emergencyLane, 4'b0010);
    end

    // Lane 1 releases in its third grant cycle; grant still lasts MIN_GREEN.
    cycle();
    cycle();
    emergencyReq = 4'b0000;
    cnt_g = 3;
    n = 0;
    while (emergencyLane != 0 && n < 40) begin cycle(); if (emergencyLane != 0) cnt_g++; n++; end
    check("s2_hold", cnt_g, MINC);
    cnt_y = 0;
    cnt_c = 0;
    n = 0;
    while (preempt && n < 40) begin
      if (yellowLane == 4'b0010) cnt_y++;
      if (allRed) cnt_c++;
      cycle();
      n++;
    end
    check("s2_yellow_len", cnt_y, Y);
    check("s2_clear_len", cnt_c, C);
    check("s2_idle", preempt, 0);

    // Lanes 0 and 2 contend: MAX_GREEN rotation 0, 2, 0.
    do_reset();
    grant_log.delete();
    normalGreen  = 4'b0000;
    emergencyReq = 4'b0101;
    for (int c = 0; c < 130; c++) cycle();
    check("s3_count", grant_log.size() >= 3, 1);
    if (grant_log.size() >= 3) begin
      check("s3_g0", grant_log[0], 4'b0001);
      check("s3_g1", grant_log[1], 4'b0100);
      check("s3_g2", grant_log[2], 4'b0001);
    end
    emergencyReq = 4'b0000;
    run_to_idle(100);

    // One-cycle pulse vanishes before arbitration: no grant issued.
    normalGreen  = 4'b0001;
    emergencyReq = 4'b0100;
    cycle();
    emergencyReq = 4'b0000;
    normalGreen  = 4'b1111;
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      cycle();
      if (emergencyLane != 0) seen = 1'b1;
    end
    check("s4_nogrant", seen, 0);
    check("s4_idle", preempt, 0);

    // Asynchronous reset during GRANT, then 1111 grants lane 0.
    normalGreen  = 4'b0000;
    emergencyReq = 4'b0100;
    for (int c = 0; c < C + 3; c++) cycle();
    check("s5_in_grant", emergencyLane, 4'b0100);
    #2 rstN = 1'b0;
    #1;
    check("s5_rst_lane", emergencyLane, 0);
    check("s5_rst_preempt", preempt, 0);
    check("s5_rst_allred", allRed, 0);
    check("s5_rst_yellow", yellowLane, 0);
    emergencyReq = 4'b1111;
    cycle();
    cycle();
    rstN = 1'b1;
    for (int c = 0; c < C + 1; c++) cycle();
    check("s5_lane0", emergencyLane, 4'b0001);

    // Random traffic against the model.
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 7) == 0)
        emergencyReq = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom);
      normalGreen = 4'($urandom);
      cycle();
    end
    emergencyReq = 4'b0000;
    run_to_idle(200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
